alu_seq: RTL and testbench

Registered, parametrised-width ALU with a valid/ready handshake on both the operand and result sides. It adds status flags, a shift operation and a multi-cycle shift-add multiplier. It executes one operation at a time and sits between an operand-issuing controller and a result consumer that may apply backpressure. Single-cycle operations can stream at one result per clock when the consumer keeps `out_ready` high.

---
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle logic ops,
// add/sub with flags, shift-left, and an iterative shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_NOT = 3'd4, OP_SHL = 3'd5, OP_MUL = 3'd6, OP_ILL = 3'd7
    } op_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic               accept;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic               res_e;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    assign sum_ext  = {1'b0, in1} + {1'b0, in2};
    assign diff_ext = {1'b0, in1} - {1'b0, in2};

    // Single-cycle result path; MUL is handled by the sequential datapath below.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        case (op_t'(opcode))
            OP_ADD: begin
                res   = sum_ext[WIDTH-1:0];
                res_c = sum_ext[WIDTH];
                res_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff_ext[WIDTH-1:0];
                res_c = diff_ext[WIDTH];
                res_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: res = in1 & in2;
            OP_OR:  res = in1 | in2;
            OP_NOT: res = ~in1;
            OP_SHL: res = (32'(in2) >= 32'(WIDTH)) ? '0 : (in1 << in2);
            OP_MUL: res = '0;
            default: res_e = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            out    <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
        end else if (state == BUSY) begin
            if (cnt != '0) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
            end else begin
                out    <= acc[WIDTH-1:0];
                flag_z <= (acc[WIDTH-1:0] == '0);
                flag_c <= |acc[2*WIDTH-1:WIDTH];
                flag_v <= 1'b0;
                err    <= 1'b0;
                state  <= HOLD;
            end
        end else if (accept) begin
            if (op_t'(opcode) == OP_MUL) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, in1};
                mplier <= in2;
                cnt    <= CNT_W'(WIDTH);
                state  <= BUSY;
            end else begin
                out    <= res;
                flag_z <= (res == '0);
                flag_c <= res_c;
                flag_v <= res_v;
                err    <= res_e;
                state  <= HOLD;
            end
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table for single-cycle ops,
// hand-written sequences for MUL latency, backpressure, streaming and mid-MUL reset.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .flag_z(flag_z), .flag_c(flag_c),
        .flag_v(flag_v), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        logic       c;
        logic       v;
        logic       e;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] y, input logic z,
                                input logic c, input logic v, input logic e);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " out"},   32'(out), 32'(y));
        check({name, " flags"}, {28'd0, flag_z, flag_c, flag_v, err}, {28'd0, z, c, v, e});
    endtask

    // Single-cycle op from IDLE: accept, check result one cycle later, then release.
    task automatic run_single(input vec_t t);
        @(negedge clk);
        check({t.name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        opcode    = t.op;
        in1       = t.a;
        in2       = t.b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1      = 8'h55;
        in2      = 8'h33;
        check_result(t.name, t.y, t.z, t.c, t.v, t.e);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({t.name, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] y, input logic z, input logic c);
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = 3'd6;
        in1       = a;
        in2       = b;
        out_ready = 1'b0;
        @(posedge clk);
        // Offer a competing ADD throughout BUSY; it must be ignored.
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            opcode = 3'd0;
            in1    = 8'h01;
            in2    = 8'h01;
            if (k == 8) in_valid = 1'b0;
            check($sformatf("%s busy%0d valid", name, k), 32'(out_valid), 32'd0);
            check($sformatf("%s busy%0d ready", name, k), 32'(in_ready), 32'd0);
            if (k < 8) @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check_result(name, y, z, c, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"add_carry",   3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"add_ovf",     3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{"add_wrap",    3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"sub_ovf",     3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"sub_zero",    3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"sub_borrow",  3'd1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"and",         3'd2, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"or",          3'd3, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"not",         3'd4, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"shl1",        3'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"shl7",        3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"shl8",        3'd5, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"illegal",     3'd7, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 3'd0;
        in1       = 8'h00;
        in2       = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {22'd0, out_valid, out, flag_z, flag_c, flag_v, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_single(vecs[i]);

        run_mul("mul_15x17", 8'd15, 8'd17, 8'hFF, 1'b0, 1'b0);
        run_mul("mul_16x16", 8'd16, 8'd16, 8'h00, 1'b1, 1'b1);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = 3'd0;
        in1       = 8'd3;
        in2       = 8'd4;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in1 = 8'd9;
        in2 = 8'd9;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d", k), {22'd0, out_valid, in_ready, out},
                  {22'd0, 1'b1, 1'b0, 8'd7});
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp in_ready comb", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp valid drop", 32'(out_valid), 32'd0);

        // Streaming: three ops on consecutive edges, results on consecutive cycles.
        in_valid = 1'b1;
        opcode   = 3'd2;
        in1      = 8'hCC;
        in2      = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        check_result("stream_and", 8'h88, 1'b0, 1'b0, 1'b0, 1'b0);
        opcode = 3'd3;
        @(posedge clk);
        @(negedge clk);
        check_result("stream_or", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        opcode = 3'd4;
        in1    = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("stream_not", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("stream end", 32'(out_valid), 32'd0);

        // Reset during the 4th BUSY cycle of a MUL.
        in_valid  = 1'b1;
        opcode    = 3'd6;
        in1       = 8'd15;
        in2       = 8'd17;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid-mul reset outputs", {22'd0, out_valid, out, flag_z, flag_c, flag_v, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("no stale %0d", k), 32'(out_valid), 32'd0);
        end
        run_single('{"add_after_reset", 3'd0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
